sobel_stream_ctrl: RTL and testbench

- Streams a WIDTH x HEIGHT 8-bit grayscale frame from an input FIFO through a 2*WIDTH+3 pixel line/shift buffer.
- Presents a 3x3 window to the external combinational sobel filter and writes the filter result to an output FIFO, one output pixel per input pixel.
- Border pixels (first/last row and column) are forced to 0.
- Sits between the grayscale FIFO and the edge-image FIFO in the image pipeline; sequences start-up fill, steady state, end-of-frame flush and drain.

---
 rtl/sobel_stream_ctrl.sv | 130 +++++++++++++
 tb/tb_sobel_stream_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_ctrl.sv
// Streams a WIDTH x HEIGHT frame through a 2*WIDTH+3 line/shift buffer and writes one sobel result per pixel.
// First write one cycle after the (WIDTH+2)th pop; a pending window stalls the shifter while out_full is high.
module sobel_stream_ctrl #(
  parameter int WIDTH           = 720,
  parameter int HEIGHT          = 540,
  parameter int GRAY_DATA_WIDTH = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [GRAY_DATA_WIDTH-1:0]      in_dout,
  input  logic                            in_empty,
  output logic                            in_rd_en,
  output logic [8:0][GRAY_DATA_WIDTH-1:0] win_dout,
  input  logic [GRAY_DATA_WIDTH-1:0]      filt_din,
  output logic [GRAY_DATA_WIDTH-1:0]      out_din,
  output logic                            out_wr_en,
  input  logic                            out_full,
  output logic                            frame_done
);

  localparam int SR_LEN = 2*WIDTH + 3;
  localparam int CW     = $clog2(WIDTH*HEIGHT + WIDTH + 2);

  localparam logic [CW-1:0] S_WIN      = CW'(WIDTH + 2);
  localparam logic [CW-1:0] S_LAST_POP = CW'(WIDTH*HEIGHT);
  localparam logic [CW-1:0] S_END      = CW'(WIDTH*HEIGHT + WIDTH + 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ROW_LAST   = CW'(HEIGHT - 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [GRAY_DATA_WIDTH-1:0] sr_q [SR_LEN];
  logic [CW-1:0]              s_q, s_d, s_inc;
  logic [CW-1:0]              row_q, row_d, col_q, col_d;
  logic                       win_valid_q, win_valid_d;
  logic                       border_q, border_d;
  logic                       source_ok, adv;
  logic [GRAY_DATA_WIDTH-1:0] shift_dat;

  assign win_dout[8] = sr_q[0];
  assign win_dout[7] = sr_q[1];
  assign win_dout[6] = sr_q[2];
  assign win_dout[5] = sr_q[WIDTH];
  assign win_dout[4] = sr_q[WIDTH+1];
  assign win_dout[3] = sr_q[WIDTH+2];
  assign win_dout[2] = sr_q[2*WIDTH];
  assign win_dout[1] = sr_q[2*WIDTH+1];
  assign win_dout[0] = sr_q[2*WIDTH+2];

  assign out_din = (win_valid_q && !border_q) ? filt_din : '0;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    row_d       = row_q;
    col_d       = col_q;
    win_valid_d = win_valid_q;
    border_d    = border_q;
    source_ok   = 1'b0;
    shift_dat   = '0;
    frame_done  = 1'b0;
    s_inc       = s_q + 1'b1;
    out_wr_en   = win_valid_q & ~out_full;

    case (state_q)
      S_RUN: begin
        source_ok = ~in_empty;
        shift_dat = in_dout;
      end
      S_FLUSH: source_ok = 1'b1;
      default: ;
    endcase

    // A held window may only be replaced in the same cycle it is written.
    adv      = (~win_valid_q | ~out_full) & source_ok;
    in_rd_en = adv & (state_q == S_RUN) & ~reset;

    if (adv) begin
      s_d         = s_inc;
      win_valid_d = (s_inc >= S_WIN);
      if (s_inc >= S_WIN) begin
        border_d = (row_q == '0) || (row_q == ROW_LAST) ||
                   (col_q == '0) || (col_q == COL_LAST);
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      if (state_q == S_RUN && s_inc == S_LAST_POP) state_d = S_FLUSH;
      if (state_q == S_FLUSH && s_inc == S_END)    state_d = S_DRAIN;
    end else if (out_wr_en) begin
      win_valid_d = 1'b0;
    end

    if (state_q == S_DRAIN && !win_valid_q) begin
      frame_done = 1'b1;
      s_d        = '0;
      row_d      = '0;
      col_d      = '0;
      state_d    = S_RUN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      s_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      win_valid_q <= 1'b0;
      border_q    <= 1'b0;
      for (int i = 0; i < SR_LEN; i++) sr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_valid_q <= win_valid_d;
      border_q    <= border_d;
      if (adv) begin
        sr_q[0] <= shift_dat;
        for (int i = 1; i < SR_LEN; i++) sr_q[i] <= sr_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Directed bench: a 4x4 instance for the main scenarios and a 3x3 instance for the single-pixel case.
module tb_sobel_stream_ctrl;

  localparam int W = 4;
  localparam int H = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [7:0]      a_in, a_filt, a_out;
  logic            a_empty, a_rd, a_wr, a_full, a_fd;
  logic [8:0][7:0] a_win;
  logic [7:0]      b_in, b_filt, b_out;
  logic            b_empty, b_rd, b_wr, b_full, b_fd;
  logic [8:0][7:0] b_win;

  sobel_stream_ctrl #(.WIDTH(W), .HEIGHT(H), .GRAY_DATA_WIDTH(8)) dut_a (
    .clock(clock), .reset(reset), .in_dout(a_in), .in_empty(a_empty), .in_rd_en(a_rd),
    .win_dout(a_win), .filt_din(a_filt), .out_din(a_out), .out_wr_en(a_wr),
    .out_full(a_full), .frame_done(a_fd));

  sobel_stream_ctrl #(.WIDTH(3), .HEIGHT(3), .GRAY_DATA_WIDTH(8)) dut_b (
    .clock(clock), .reset(reset), .in_dout(b_in), .in_empty(b_empty), .in_rd_en(b_rd),
    .win_dout(b_win), .filt_din(b_filt), .out_din(b_out), .out_wr_en(b_wr),
    .out_full(b_full), .frame_done(b_fd));

  function automatic logic [7:0] sobel(input logic [8:0][7:0] w);
    int gx, gy, m;
    gx = (int'(w[2]) + 2*int'(w[5]) + int'(w[8])) - (int'(w[0]) + 2*int'(w[3]) + int'(w[6]));
    gy = (int'(w[6]) + 2*int'(w[7]) + int'(w[8])) - (int'(w[0]) + 2*int'(w[1]) + int'(w[2]));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = (gx + gy) / 2;
    if (m > 255) m = 255;
    return 8'(m);
  endfunction

  always_comb a_filt = sobel(a_win);
  always_comb b_filt = sobel(b_win);

  int total = 0;
  int bad   = 0;
  int cyc, pops, pops_fr, wr_fr, writes, fdone, first_wr, sixth_pop, last_wr, fd_cyc, viol;
  bit tmo;
  logic [7:0] outq[$];
  logic [7:0] src[$];
  int src_idx;
  logic [7:0] ramp_exp [16];

  task automatic clear_log();
    cyc = 0; pops = 0; pops_fr = 0; wr_fr = 0; writes = 0; fdone = 0;
    first_wr = -1; sixth_pop = -1; last_wr = -1; fd_cyc = -1; viol = 0; tmo = 0;
    outq.delete();
    src.delete();
    src_idx = 0;
  endtask

  task automatic load_ramp(input int frames);
    for (int i = 0; i < 16*frames; i++) src.push_back(8'((i % 4) * 10));
  endtask

  // Drives dut_a one cycle per negedge, sampling its outputs 1ns later.
  task automatic run(input int budget, input bit rnd, input int full_at, input int full_len,
                     input int fd_target, input int stop_pops);
    int pend;
    tmo = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      cyc++;
      a_in    = (src_idx < src.size()) ? src[src_idx] : 8'd0;
      a_empty = (src_idx >= src.size()) || (rnd && $urandom_range(0, 2) == 0);
      a_full  = (cyc >= full_at) && (cyc < full_at + full_len);
      #1;
      pend = pops_fr - (W + 1) - wr_fr;
      if (a_rd && (a_empty || (a_full && pend > 0))) viol++;
      if (a_wr && a_full) viol++;
      if (a_rd) begin
        pops++; pops_fr++; src_idx++;
        if (pops_fr == W + 2 && sixth_pop < 0) sixth_pop = cyc;
      end
      if (a_wr) begin
        outq.push_back(a_out);
        writes++; wr_fr++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (a_fd) begin
        fdone++; fd_cyc = cyc; pops_fr = 0; wr_fr = 0;
      end
      if ((fd_target > 0 && fdone >= fd_target) || (stop_pops > 0 && pops >= stop_pops)) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    a_empty = 1'b0; a_in = 8'hAB; a_full = 1'b0;
    b_empty = 1'b0; b_in = 8'hCD; b_full = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    total++; if (a_rd !== 1'b0) begin bad++; $display("FAIL reset_rd: got %b want 0", a_rd); end
    total++; if (a_wr !== 1'b0) begin bad++; $display("FAIL reset_wr: got %b want 0", a_wr); end
    total++; if (a_fd !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b want 0", a_fd); end
    total++; if (a_out !== 8'd0) begin bad++; $display("FAIL reset_out: got %0d want 0", a_out); end
    total++; if (a_win !== 72'd0) begin bad++; $display("FAIL reset_win: got %h want 0", a_win); end
    total++; if (b_rd !== 1'b0) begin bad++; $display("FAIL reset_b_rd: got %b want 0", b_rd); end
    a_empty = 1'b1;
    b_empty = 1'b1;
    reset = 1'b0;
  endtask

  task automatic test_constant();
    int nz;
    clear_log();
    for (int i = 0; i < 16; i++) src.push_back(8'd100);
    run(200, 1'b0, 0, 0, 1, 0);
    nz = 0;
    foreach (outq[i]) if (outq[i] !== 8'd0) nz++;
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL const_timeout: got %0d want 0", tmo); end
    total++; if (writes != 16) begin bad++; $display("FAIL const_writes: got %0d want 16", writes); end
    total++; if (nz != 0) begin bad++; $display("FAIL const_nonzero: got %0d want 0", nz); end
    total++; if (pops != 16) begin bad++; $display("FAIL const_pops: got %0d want 16", pops); end
    total++; if (first_wr != sixth_pop + 1)
      begin bad++; $display("FAIL const_latency: got %0d want %0d", first_wr, sixth_pop + 1); end
    total++; if (last_wr - first_wr != 15)
      begin bad++; $display("FAIL const_throughput: got %0d want 15", last_wr - first_wr); end
    total++; if (fd_cyc != last_wr + 1)
      begin bad++; $display("FAIL const_fd_cycle: got %0d want %0d", fd_cyc, last_wr + 1); end
    total++; if (fdone != 1) begin bad++; $display("FAIL const_fdone: got %0d want 1", fdone); end
  endtask

  task automatic check_ramp(input string name, input int frames);
    total++;
    if (outq.size() != 16*frames) begin
      bad++; $display("FAIL %s_len: got %0d want %0d", name, outq.size(), 16*frames);
    end else begin
      for (int i = 0; i < 16*frames; i++) begin
        total++;
        if (outq[i] !== ramp_exp[i % 16]) begin
          bad++; $display("FAIL %s_pix%0d: got %0d want %0d", name, i, outq[i], ramp_exp[i % 16]);
        end
      end
    end
  endtask

  task automatic test_ramp();
    clear_log();
    load_ramp(1);
    run(200, 1'b0, 0, 0, 1, 0);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL ramp_timeout: got %0d want 0", tmo); end
    check_ramp("ramp", 1);
    total++; if (fdone != 1) begin bad++; $display("FAIL ramp_fdone: got %0d want 1", fdone); end
  endtask

  task automatic test_stall();
    clear_log();
    load_ramp(1);
    run(600, 1'b1, 10, 20, 1, 0);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL stall_timeout: got %0d want 0", tmo); end
    check_ramp("stall", 1);
    total++; if (viol != 0) begin bad++; $display("FAIL stall_handshake: got %0d want 0", viol); end
    total++; if (pops != 16) begin bad++; $display("FAIL stall_pops: got %0d want 16", pops); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    load_ramp(2);
    run(400, 1'b0, 0, 0, 2, 0);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL b2b_timeout: got %0d want 0", tmo); end
    check_ramp("b2b", 2);
    total++; if (fdone != 2) begin bad++; $display("FAIL b2b_fdone: got %0d want 2", fdone); end
    total++; if (pops != 32) begin bad++; $display("FAIL b2b_pops: got %0d want 32", pops); end
  endtask

  task automatic test_mid_reset();
    int nz;
    clear_log();
    for (int i = 0; i < 16; i++) src.push_back(8'(100 + i));
    run(100, 1'b0, 0, 0, 0, 7);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL mrst_reach7: got %0d want 0", tmo); end
    @(posedge clock);
    #1;
    total++; if (a_wr !== 1'b1) begin bad++; $display("FAIL mrst_pending: got %b want 1", a_wr); end
    reset = 1'b1;
    #1;
    total++; if (a_rd !== 1'b0) begin bad++; $display("FAIL mrst_rd: got %b want 0", a_rd); end
    total++; if (a_wr !== 1'b0) begin bad++; $display("FAIL mrst_wr: got %b want 0", a_wr); end
    total++; if (a_out !== 8'd0) begin bad++; $display("FAIL mrst_out: got %0d want 0", a_out); end
    total++; if (a_fd !== 1'b0) begin bad++; $display("FAIL mrst_fd: got %b want 0", a_fd); end
    @(negedge clock);
    a_empty = 1'b1;
    reset = 1'b0;
    clear_log();
    for (int i = 0; i < 16; i++) src.push_back(8'd50);
    run(200, 1'b0, 0, 0, 1, 0);
    nz = 0;
    foreach (outq[i]) if (outq[i] !== 8'd0) nz++;
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL mrst_timeout: got %0d want 0", tmo); end
    total++; if (writes != 16) begin bad++; $display("FAIL mrst_writes: got %0d want 16", writes); end
    total++; if (nz != 0) begin bad++; $display("FAIL mrst_nonzero: got %0d want 0", nz); end
    total++; if (fdone != 1) begin bad++; $display("FAIL mrst_fdone: got %0d want 1", fdone); end
    total++; if (pops != 16) begin bad++; $display("FAIL mrst_pops: got %0d want 16", pops); end
  endtask

  task automatic test_3x3();
    logic [7:0] px [9];
    int idx, nwr, nz, fd, centre;
    bit done;
    for (int i = 0; i < 9; i++) px[i] = 8'd0;
    px[4] = 8'd200;
    idx = 0; nwr = 0; nz = 0; fd = 0; centre = -1; done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      b_in    = (idx < 9) ? px[idx] : 8'd0;
      b_empty = (idx >= 9);
      b_full  = 1'b0;
      #1;
      if (b_rd) idx++;
      if (b_wr) begin
        if (b_out !== 8'd0) nz++;
        if (nwr == 4) centre = int'(b_win[4]);
        nwr++;
      end
      if (b_fd) begin
        fd++;
        done = 1'b1;
        break;
      end
    end
    b_empty = 1'b1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL s3_timeout: got %0d want 1", done); end
    total++; if (nwr != 9) begin bad++; $display("FAIL s3_writes: got %0d want 9", nwr); end
    total++; if (nz != 0) begin bad++; $display("FAIL s3_nonzero: got %0d want 0", nz); end
    total++; if (centre != 200) begin bad++; $display("FAIL s3_centre_win: got %0d want 200", centre); end
    total++; if (idx != 9) begin bad++; $display("FAIL s3_pops: got %0d want 9", idx); end
    total++; if (fd != 1) begin bad++; $display("FAIL s3_fdone: got %0d want 1", fd); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      ramp_exp[i] = ((i / 4 == 1 || i / 4 == 2) && (i % 4 == 1 || i % 4 == 2)) ? 8'd40 : 8'd0;
    test_reset();
    test_constant();
    test_ramp();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_3x3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
